// File: rtl/start_req_conditioner_pkg.sv
// Shared types and default timing constants for the start-request conditioner.
// START_HOLDOFF_EN adds the HOLDOFF lockout state to the state encoding.
package start_ctrl_pkg;

  localparam int DEB_1MS_50MHZ      = 50000;
  localparam int HOLDOFF_20MS_50MHZ = 1000000;

`ifdef START_HOLDOFF_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_DEB_PRESS, ST_PULSE, ST_WAIT_REL, ST_DEB_REL, ST_HOLDOFF
  } start_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_DEB_PRESS, ST_PULSE, ST_WAIT_REL, ST_DEB_REL
  } start_state_t;
`endif

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/start_req_conditioner_if.sv
// Start-request bundle: raw request in, clean pulse / status / press count out.
interface start_req_conditioner_if #(
  parameter int CNT_W = 8
);
  logic             raw_start;
  logic             start_out;
  logic             busy;
  logic [CNT_W-1:0] press_count;

  modport master (output raw_start, input start_out, busy, press_count);
  modport slave  (input raw_start, output start_out, busy, press_count);
endinterface

// File: rtl/start_req_conditioner_sync_2ff.sv
// Generic two-flop synchroniser; reset value selectable so an idle input
// never looks asserted coming out of reset.
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= {2{RST_VAL}};
    else     ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/start_req_conditioner.sv
// Synchronises and debounces a raw start request into one fixed-width pulse
// per press. Build option START_HOLDOFF_EN adds a post-release lockout.
module start_req_conditioner
  import start_ctrl_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEB_1MS_50MHZ,
  parameter int PULSE_CYCLES    = 4,
  parameter int CNT_W           = 8,
  parameter int HOLDOFF_CYCLES  = HOLDOFF_20MS_50MHZ
) (
  input logic                    clk,
  input logic                    reset,
  start_req_conditioner_if.slave bus
);

  if (DEBOUNCE_CYCLES < 1 || PULSE_CYCLES < 1 || HOLDOFF_CYCLES < 1 || CNT_W < 1) begin : g_param_chk
    $error("start_req_conditioner: cycle parameters and CNT_W must be >= 1");
  end

`ifdef START_HOLDOFF_EN
  localparam int LONGEST = max_int(max_int(DEBOUNCE_CYCLES, PULSE_CYCLES), HOLDOFF_CYCLES);
`else
  localparam int LONGEST = max_int(DEBOUNCE_CYCLES, PULSE_CYCLES);
`endif
  localparam int TW = $clog2(LONGEST) + 1;

  localparam logic [TW-1:0] DEB_LD = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] PUL_LD = TW'(PULSE_CYCLES - 1);
`ifdef START_HOLDOFF_EN
  localparam logic [TW-1:0] HLD_LD = TW'(HOLDOFF_CYCLES - 1);
`endif

  logic raw_sync, act;

  sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
    .clk (clk),
    .rst (reset),
    .d_i (bus.raw_start),
    .q_o (raw_sync)
  );

  assign act = raw_sync ^ ACTIVE_LOW;

  start_state_t     state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             start_q, busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      start_q <= (state_d == ST_PULSE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (act) begin
          state_d = ST_DEB_PRESS;
          cnt_d   = DEB_LD;
        end
      end
      ST_DEB_PRESS: begin
        if (!act) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = PUL_LD;
          if (pcnt_q != {CNT_W{1'b1}}) pcnt_d = pcnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // input deliberately ignored so the pulse width never varies
      ST_PULSE: begin
        if (cnt_q == '0) state_d = ST_WAIT_REL;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_WAIT_REL: begin
        if (!act) begin
          state_d = ST_DEB_REL;
          cnt_d   = DEB_LD;
        end
      end
      ST_DEB_REL: begin
        if (act) begin
          state_d = ST_WAIT_REL;
        end else if (cnt_q == '0) begin
`ifdef START_HOLDOFF_EN
          state_d = ST_HOLDOFF;
          cnt_d   = HLD_LD;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef START_HOLDOFF_EN
      ST_HOLDOFF: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.start_out   = start_q;
  assign bus.busy        = busy_q;
  assign bus.press_count = pcnt_q;

endmodule

// File: tb/tb_start_req_conditioner.sv
// Randomised-gap scoreboard bench for start_req_conditioner: a press/release
// run-length model predicts pulses, busy and press_count.
module tb_start_req_conditioner;

  localparam int D    = 8;
  localparam int P    = 4;
  localparam int CW   = 2;
  localparam int H    = 20;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  start_req_conditioner_if #(.CNT_W(CW)) bus_if ();

  start_req_conditioner #(
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (D),
    .PULSE_CYCLES    (P),
    .CNT_W           (CW),
    .HOLDOFF_CYCLES  (H)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A press is accepted after D+1 consecutive pressed samples while seeking;
  // the pulse then lasts P cycles, after which D+1 consecutive released
  // samples are needed (plus an H-cycle lockout in the holdoff build).
  typedef enum {M_SEEK, M_PULSE, M_REL, M_HOLD} mph_t;
  typedef struct {int edge_n; int cnt;} pev_t;

  mph_t ph = M_SEEK;
  int   run = 0, ign = 0, mcnt = 0, cyc = 0;
  int   pushed = 0, seen = 0;
  logic h1 = 1'b1, h2 = 1'b1;
  pev_t exp_q[$];

  task automatic model_step();
    logic pressed;
    cyc++;
    if (reset) begin
      ph = M_SEEK; run = 0; ign = 0; mcnt = 0; h1 = 1'b1; h2 = 1'b1;
    end else begin
      pressed = (h2 == 1'b0);
      case (ph)
        M_SEEK: begin
          run = pressed ? run + 1 : 0;
          if (run == D + 1) begin
            if (mcnt < CMAX) mcnt++;
            exp_q.push_back('{cyc, mcnt});
            pushed++;
            ph = M_PULSE; ign = P;
          end
        end
        M_PULSE: begin
          ign--;
          if (ign == 0) begin ph = M_REL; run = 0; end
        end
        M_REL: begin
          run = pressed ? 0 : run + 1;
          if (run == D + 1) begin
            run = 0;
`ifdef START_HOLDOFF_EN
            ph = M_HOLD; ign = H;
`else
            ph = M_SEEK;
`endif
          end
        end
        M_HOLD: begin
          ign--;
          if (ign == 0) begin ph = M_SEEK; run = 0; end
        end
        default: ph = M_SEEK;
      endcase
      h2 = h1;
      h1 = bus_if.raw_start;
    end
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor_proc
    logic prev;
    int   width;
    pev_t e;
    prev = 1'b0;
    width = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
        width = 0;
      end else begin
        chk("busy", bus_if.busy, !(ph == M_SEEK && run == 0));
        chk("press_count", bus_if.press_count, mcnt);
        if (bus_if.start_out) begin
          if (!prev) begin
            seen++;
            width = 0;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL pulse_unexpected: start_out rose at edge %0d, none predicted", cyc);
            end else begin
              e = exp_q.pop_front();
              chk("pulse_edge", cyc, e.edge_n);
              chk("pulse_count", bus_if.press_count, e.cnt);
            end
          end
          width++;
        end else if (prev) begin
          chk("pulse_width", width, P);
        end
        prev = bus_if.start_out;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input int n);
    @(negedge clk);
    bus_if.raw_start = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wait_rise(input string name, input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus_if.start_out) break;
    end
    chk(name, i < lim, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // start_out must be low after edge 10 and high after edge 11 of a fresh press
  task automatic check_latency(input string tag);
    repeat (10) @(posedge clk);
    #1 chk({tag, "_lo_e10"}, bus_if.start_out, 0);
    @(posedge clk);
    #1 chk({tag, "_hi_e11"}, bus_if.start_out, 1);
  endtask

  int base;

  initial begin : stim
    bus_if.raw_start = 1'b1;
    #2;
    chk("rst_start_out", bus_if.start_out, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_press_count", bus_if.press_count, 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // clean press
    base = seen;
    @(negedge clk);
    bus_if.raw_start = 1'b0;
    check_latency("clean");
    repeat (3) @(posedge clk);
    #1 chk("clean_hi_e14", bus_if.start_out, 1);
    @(posedge clk);
    #1 chk("clean_lo_e15", bus_if.start_out, 0);
    repeat (25) @(negedge clk);
    drive(1'b1, 40);
    chk("clean_pulses", seen - base, 1);
    chk("clean_count", bus_if.press_count, 1);

    // bounce rejection
    base = seen;
    for (int k = 0; k < 10; k++) drive((k % 2 == 0) ? 1'b0 : 1'b1, 3);
    drive(1'b1, 20);
    chk("bounce_pulses", seen - base, 0);
    chk("bounce_busy", bus_if.busy, 0);
    chk("bounce_count", bus_if.press_count, 1);

    // long hold with release bounce
    base = seen;
    drive(1'b0, 200);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3);
      drive(1'b0, 2);
    end
    drive(1'b1, 40);
    chk("long_pulses", seen - base, 1);
    chk("long_busy", bus_if.busy, 0);

    // saturation, randomised press/release lengths
    pulse_reset();
    base = seen;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 12 + int'($urandom_range(0, 15)));
      drive(1'b1, 35 + int'($urandom_range(0, 10)));
    end
    chk("sat_pulses", seen - base, 5);
    chk("sat_count", bus_if.press_count, CMAX);

    // reset two cycles into the pulse, input still held
    @(negedge clk);
    bus_if.raw_start = 1'b0;
    wait_rise("rst_mid_rise_seen", 30);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_start_out", bus_if.start_out, 0);
    chk("rst_mid_busy", bus_if.busy, 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    check_latency("rerelease");
    repeat (10) @(negedge clk);
    drive(1'b1, 40);
    chk("rerelease_count", bus_if.press_count, 1);

    // spacing after a completed release (holdoff build ignores the short press)
    drive(1'b0, 20);
    drive(1'b1, 21);
    drive(1'b0, 12);
    drive(1'b1, 3);
    drive(1'b0, 20);
    drive(1'b1, 40);

    // random short glitches mixed with real presses
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1 + int'($urandom_range(0, 14)));
      drive(1'b1, 1 + int'($urandom_range(0, 40)));
    end
    drive(1'b1, 40);

    chk("queue_drained", exp_q.size(), 0);
    chk("pulses_seen", seen, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
